stopwatch_ctrl: RTL

Control sequencer for the stopwatch datapath. Debounces the start/stop and lap/reset buttons, runs the stopwatch mode state machine, and generates the centisecond count-enable tick. It also drives the synchronous clear for the BCD counter chain and a display-hold strobe for the 7-segment scanner. It sits between the board buttons and the existing counter/display path and replaces the ad-hoc edge catcher.

---
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, mode FSM, centisecond
// tick divider and registered counter/display control strobes.
module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_DIV        = 500000
) (
   input  logic       mclk,
   input  logic       clear,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic [1:0] state
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } mode_t;

   // Bit 0 is the start/stop button, bit 1 the lap/reset button.
   logic [1:0]    meta, sync, lvl, lvl_d, ev;
   logic [DW-1:0] db_cnt [2];

   mode_t         st_q, st_n;
   logic          clr_n, clr_q;
   logic          run_q, run_n, tick;
   logic [TW-1:0] div;

   always_ff @(posedge mclk) begin
      if (!clear) begin
         meta  <= '0;
         sync  <= '0;
         lvl   <= '0;
         lvl_d <= '0;
         ev    <= '0;
         // NOTE: db_cnt is an array of plain flops, not a RAM, so it is reset like any other register.
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         meta  <= {btn_lap, btn_ss};
         sync  <= meta;
         lvl_d <= lvl;
         ev    <= lvl_d & ~lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               lvl[i]    <= ~lvl[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // ev[0] is tested first, so start/stop wins over a simultaneous lap event.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      st_n  = st_q;
      clr_n = 1'b0;
      case (st_q)
         IDLE: begin
            if (ev[0])      st_n  = RUN;
            else if (ev[1]) clr_n = 1'b1;
         end
         RUN: begin
            if (ev[0])      st_n = PAUSE;
            else if (ev[1]) st_n = LAP;
         end
         LAP: begin
            if (ev[0])      st_n = PAUSE;
            else if (ev[1]) st_n = RUN;
         end
         PAUSE: begin
            if (ev[0]) begin
               st_n = RUN;
            end else if (ev[1]) begin
               st_n  = IDLE;
               clr_n = 1'b1;
            end
         end
         default: st_n = IDLE;
      endcase
   end

   assign run_q = (st_q == RUN) || (st_q == LAP);
   assign run_n = (st_n == RUN) || (st_n == LAP);
   // A tick due on the edge that leaves RUN/LAP is held back and issued on resume.
   assign tick  = run_q && run_n && (div == TICK_LAST);

   always_ff @(posedge mclk) begin
      if (!clear) begin
         st_q      <= IDLE;
         clr_q     <= 1'b0;
         div       <= '0;
         cnt_en    <= 1'b0;
         disp_hold <= 1'b0;
         cnt_clr   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every register see the pre-edge values of the others.
         st_q      <= st_n;
         clr_q     <= clr_n;
         cnt_clr   <= clr_q;
         disp_hold <= (st_q == LAP);
         cnt_en    <= tick;
         if (st_q == IDLE) begin
            div <= '0;
         end else if (run_q) begin
            if (div != TICK_LAST) div <= div + 1'b1;
            else if (run_n)       div <= '0;
         end
      end
   end

   assign state = st_q;

endmodule
